ysyx_23060278_idu: RTL and testbench

//  Registered instruction-decode stage between IFU and EXU. Accepts fetched {pc, inst} over a

---
 rtl/ysyx_23060278_idu.sv | 152 +++++++++++++++
 tb/tb_ysyx_23060278_idu.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060278_idu.sv
// Instruction-decode stage: decodes fetched {pc, inst} and buffers the
// decoded result in a small FIFO so fetch runs ahead of execute stalls.
module ysyx_23060278_idu #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_type,
  output logic            illegal
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam bit RV64 = (XLEN == 64);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [XLEN-1:0] imm;
    logic [2:0]      imm_type;
    logic            illegal;
  } entry_t;

  logic [6:0]  op;
  logic        op_i, op_s, op_b, op_u, op_j, op_r;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  entry_t      in_ent;

  assign op   = in_inst[6:0];
  assign op_i = (op == 7'b1100111) | (op == 7'b0000011)
              | (op == 7'b0010011) | (op == 7'b1110011)
              | (RV64 & (op == 7'b0011011));
  assign op_s = (op == 7'b0100011);
  assign op_b = (op == 7'b1100011);
  assign op_u = (op == 7'b0110111) | (op == 7'b0010111);
  assign op_j = (op == 7'b1101111);
  assign op_r = (op == 7'b0110011) | (op == 7'b0001111)
              | (RV64 & (op == 7'b0111011));

  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                  in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                  in_inst[20], in_inst[30:21], 1'b0};

  // Immediates are built at 32 bits, then sign-extended to XLEN.
  always_comb begin
    in_ent      = '0;
    in_ent.pc   = in_pc;
    in_ent.inst = in_inst;
    unique case (1'b1)
      op_i: begin
        in_ent.imm      = XLEN'($signed(imm_i));
        in_ent.imm_type = 3'd1;
      end
      op_s: begin
        in_ent.imm      = XLEN'($signed(imm_s));
        in_ent.imm_type = 3'd2;
      end
      op_b: begin
        in_ent.imm      = XLEN'($signed(imm_b));
        in_ent.imm_type = 3'd3;
      end
      op_u: begin
        in_ent.imm      = XLEN'($signed(imm_u));
        in_ent.imm_type = 3'd4;
      end
      op_j: begin
        in_ent.imm      = XLEN'($signed(imm_j));
        in_ent.imm_type = 3'd5;
      end
      op_r:    in_ent.imm_type = 3'd0;
      default: in_ent.illegal  = 1'b1;
    endcase
  end

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            push, pop;
  entry_t          head;

  assign in_ready  = (cnt_q != CW'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = in_ent;
        wr_d        = wr_q + AW'(1);
      end
      if (pop) rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head     = mem_q[rd_q];
  assign out_pc   = head.pc;
  assign opcode   = head.inst[6:0];
  assign rd       = head.inst[11:7];
  assign func3    = head.inst[14:12];
  assign rs1      = head.inst[19:15];
  assign rs2      = head.inst[24:20];
  assign func7    = head.inst[31:25];
  assign imm      = head.imm;
  assign imm_type = head.imm_type;
  assign illegal  = head.illegal;

endmodule

// File: tb/tb_ysyx_23060278_idu.sv
// Directed bench for the decode stage: one RV32 and one RV64 instance
// driven with identical stimulus.
module tb_ysyx_23060278_idu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic [63:0] pc64;

  logic        in_ready, out_valid, illegal;
  logic [31:0] out_pc, imm;
  logic [6:0]  opcode, func7;
  logic [2:0]  func3, imm_type;
  logic [4:0]  rs1, rs2, rd;

  logic        q_in_ready, q_out_valid, q_illegal;
  logic [63:0] q_out_pc, q_imm;
  logic [6:0]  q_opcode, q_func7;
  logic [2:0]  q_func3, q_imm_type;
  logic [4:0]  q_rs1, q_rs2, q_rd;

  int total = 0;
  int passed = 0;

  assign pc64 = {32'h0, in_pc};

  always #5 clk = ~clk;

  ysyx_23060278_idu #(.XLEN(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .opcode(opcode), .func3(func3),
    .func7(func7), .rs1(rs1), .rs2(rs2), .rd(rd),
    .imm(imm), .imm_type(imm_type), .illegal(illegal)
  );

  ysyx_23060278_idu #(.XLEN(64), .DEPTH(2)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(q_in_ready),
    .in_pc(pc64), .in_inst(in_inst),
    .out_valid(q_out_valid), .out_ready(out_ready),
    .out_pc(q_out_pc), .opcode(q_opcode), .func3(q_func3),
    .func7(q_func7), .rs1(q_rs1), .rs2(q_rs2), .rd(q_rd),
    .imm(q_imm), .imm_type(q_imm_type), .illegal(q_illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] pc, input logic [31:0] inst);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    cyc();
    cyc();
    out_ready = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_imm", imm, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_pc", out_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    put(32'h100, 32'hFFF00093);
    chk("addi_valid", out_valid, 1);
    chk("addi_imm", imm, 64'hFFFF_FFFF);
    chk("addi_type", imm_type, 1);
    chk("addi_rd", rd, 1);
    chk("addi_pc", out_pc, 32'h100);
    chk("addi_illegal", illegal, 0);
    chk("addi_ready", in_ready, 1);
    chk("addi_imm64", q_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    drain();
    chk("drain_valid", out_valid, 0);

    put(32'h104, 32'h12345037);
    chk("lui_imm64", q_imm, 64'h0000_0000_1234_5000);
    chk("lui_type64", q_imm_type, 4);
    chk("lui_imm", imm, 32'h1234_5000);
    chk("lui_rd", rd, 0);
    drain();
    put(32'h108, 32'h80000037);
    chk("luineg_imm64", q_imm, 64'hFFFF_FFFF_8000_0000);
    chk("luineg_imm", imm, 32'h8000_0000);
    chk("luineg_pc64", q_out_pc, 64'h108);
    drain();

    put(32'h10C, 32'hFE000EE3);
    chk("beq_imm", imm, 32'hFFFF_FFFC);
    chk("beq_type", imm_type, 3);
    chk("beq_func7", func7, 7'h7F);
    chk("beq_imm64", q_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    drain();
    put(32'h110, 32'h0000003B);
    chk("op32_illegal", illegal, 1);
    chk("op32_imm", imm, 0);
    chk("op32_type", imm_type, 0);
    chk("op32_opcode", opcode, 7'h3B);
    chk("op32_legal64", q_illegal, 0);
    chk("op32_type64", q_imm_type, 0);
    drain();
    put(32'h114, 32'hFE20AC23);
    chk("sw_imm", imm, 32'hFFFF_FFF8);
    chk("sw_type", imm_type, 2);
    chk("sw_rs1", rs1, 1);
    chk("sw_rs2", rs2, 2);
    chk("sw_func3", func3, 2);
    drain();
    put(32'h118, 32'h800000EF);
    chk("jal_imm", imm, 32'hFFF0_0000);
    chk("jal_type", imm_type, 5);
    chk("jal_rd", rd, 1);
    drain();
    put(32'h11C, 32'h00000010);
    chk("lowbits_illegal", illegal, 1);
    chk("lowbits_illegal64", q_illegal, 1);
    drain();

    put(32'h200, 32'h00100093);
    chk("fifo_ready1", in_ready, 1);
    put(32'h204, 32'h00200113);
    chk("fifo_full", in_ready, 0);
    chk("fifo_head_a", out_pc, 32'h200);
    put(32'h208, 32'h00300193);
    chk("full_hold_pc", out_pc, 32'h200);
    chk("full_hold_imm", imm, 1);
    out_ready = 1'b1;
    put(32'h208, 32'h00300193);
    chk("pop1_pc", out_pc, 32'h204);
    chk("pop1_imm", imm, 2);
    chk("pop1_ready", in_ready, 1);
    put(32'h208, 32'h00300193);
    chk("pushpop_pc", out_pc, 32'h208);
    chk("pushpop_rd", rd, 3);
    chk("pushpop_valid", out_valid, 1);
    chk("pushpop_ready", in_ready, 1);
    cyc();
    chk("fifo_empty", out_valid, 0);
    out_ready = 1'b0;

    put(32'h300, 32'h00100093);
    put(32'h304, 32'h00200113);
    flush = 1'b1;
    put(32'h308, 32'h00300193);
    flush = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);
    cyc();
    chk("flush_nostore", out_valid, 0);
    put(32'h30C, 32'h00400213);
    chk("post_flush_pc", out_pc, 32'h30C);
    chk("post_flush_imm", imm, 4);

    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_ready", in_ready, 1);
    chk("async_imm", imm, 0);
    chk("async_valid64", q_out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("after_rst_valid", out_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
